// File: rtl/ex_pkg.sv
// Purpose : shared EX-stage definitions: condition-select encodings and entry layout.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
package ex_pkg;

    // Default datapath and register-index widths; the stage parameters default to these.
    localparam int EX_DW  = 16;
    localparam int EX_RW  = 3;
    localparam int COND_W = 3;

    // Condition select encodings shared by the EX stage and decode early-branch logic.
    typedef enum logic [COND_W-1:0] {
        COND_EQ     = 3'b000,
        COND_NE     = 3'b001,
        COND_LT     = 3'b010,
        COND_GE     = 3'b011,
        COND_LE     = 3'b100,
        COND_CO     = 3'b101,
        COND_ALWAYS = 3'b110,
        COND_NEVER  = 3'b111
    } cond_op_e;

    // Entry layout at default widths: {result, branch_taken, wr_en, wr_reg}.
    typedef struct packed {
        logic [EX_DW-1:0] result;
        logic             branch_taken;
        logic             wr_en;
        logic [EX_RW-1:0] wr_reg;
    } entry_t;

    localparam int ENTRY_W = EX_DW + 2 + EX_RW;

endpackage

// File: rtl/ex_cond_stage_cond_eval.sv
// Purpose : flag-to-condition mux; shared with decode-stage early branch resolution.
// Latency : combinational.
// Backpressure : none.
//
// Ports:
//   cond_op  - condition select (ex_pkg::cond_op_e encoding)
//   flag_z / flag_n / flag_ofl - ALU zero, negative, overflow/carry flags
//   cond     - resolved condition
module cond_eval
    import ex_pkg::*;
(
    input  logic [2:0] cond_op,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       flag_ofl,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (cond_op_e'(cond_op))
            COND_EQ:     cond = flag_z;
            COND_NE:     cond = ~flag_z;
            COND_LT:     cond = flag_n;
            COND_GE:     cond = ~flag_n;
            COND_LE:     cond = flag_n | flag_z;
            COND_CO:     cond = flag_ofl;
            COND_ALWAYS: cond = 1'b1;
            COND_NEVER:  cond = 1'b0;
            default:     cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_cond_stage.sv
// Purpose : EX->MEM boundary; resolves set-on-condition/branch outcome and registers it.
// Latency : 1 cycle accept-to-out_valid; back-to-back throughput of 1 entry per cycle.
// Backpressure : 2-entry skid (main + skid); in_ready is registered and equals !skid_full.
//
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   in_valid / in_ready              - EX handshake (in_ready is a flop output)
//   alu_out, alu_ofl, alu_z, alu_n   - ALU result and flags
//   cond_op, is_set, is_branch       - condition select and instruction class
//   wr_en, wr_reg                    - destination write enable / index
//   out_valid / out_ready            - MEM handshake
//   result, branch_taken, wr_en_o, wr_reg_o - head entry contents
//   flush                            - squash held and incoming entries
//   ofl_sticky / ofl_clr             - sticky arithmetic overflow status and its clear
module ex_cond_stage
    import ex_pkg::*;
#(
    parameter int DW = EX_DW,
    parameter int RW = EX_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_ofl,
    input  logic          alu_z,
    input  logic          alu_n,
    input  logic [2:0]    cond_op,
    input  logic          is_set,
    input  logic          is_branch,
    input  logic          wr_en,
    input  logic [RW-1:0] wr_reg,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] result,
    output logic          branch_taken,
    output logic          wr_en_o,
    output logic [RW-1:0] wr_reg_o,
    input  logic          flush,
    output logic          ofl_sticky,
    input  logic          ofl_clr
);

    // Same field order as ex_pkg::entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DW-1:0] result;
        logic          branch_taken;
        logic          wr_en;
        logic [RW-1:0] wr_reg;
    } stage_entry_t;

    localparam stage_entry_t ENTRY_ZERO = '0;

    logic         main_vld_q, main_vld_d;
    logic         skid_vld_q, skid_vld_d;
    stage_entry_t main_q,     main_d;
    stage_entry_t skid_q,     skid_d;
    logic         ofl_sticky_q, ofl_sticky_d;

    logic         cond;
    logic         accept;
    logic         drain;
    stage_entry_t new_entry;

    cond_eval u_cond_eval (
        .cond_op  (cond_op),
        .flag_z   (alu_z),
        .flag_n   (alu_n),
        .flag_ofl (alu_ofl),
        .cond     (cond)
    );

    // in_ready comes straight from the skid-valid flop, so it never depends on out_ready.
    assign in_ready = ~skid_vld_q;
    assign accept   = in_valid & in_ready;
    assign drain    = main_vld_q & out_ready;

    // is_set wins over is_branch for the result field if both are (illegally) raised.
    always_comb begin
        new_entry              = ENTRY_ZERO;
        new_entry.result       = is_set ? {{(DW-1){1'b0}}, cond} : alu_out;
        new_entry.branch_taken = is_branch & cond;
        new_entry.wr_en        = wr_en;
        new_entry.wr_reg       = wr_reg;
    end

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_d     = main_q;
        skid_d     = skid_q;

        if (flush) begin
            // Drop everything; data fields keep their last values since only valid is observed.
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (drain) begin
            if (skid_vld_q) begin
                // Skid full implies in_ready=0, so no accept can coincide here.
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = new_entry;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (main_vld_q) begin
                skid_d     = new_entry;
                skid_vld_d = 1'b1;
            end else begin
                main_d     = new_entry;
                main_vld_d = 1'b1;
            end
        end
    end

    // Only plain arithmetic overflow is sticky; a set in the same cycle beats ofl_clr.
    always_comb begin
        ofl_sticky_d = ofl_sticky_q;
        if (accept & alu_ofl & ~is_set & ~is_branch & ~flush) begin
            ofl_sticky_d = 1'b1;
        end else if (ofl_clr) begin
            ofl_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_q   <= 1'b0;
            skid_vld_q   <= 1'b0;
            main_q       <= ENTRY_ZERO;
            skid_q       <= ENTRY_ZERO;
            ofl_sticky_q <= 1'b0;
        end else begin
            main_vld_q   <= main_vld_d;
            skid_vld_q   <= skid_vld_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            ofl_sticky_q <= ofl_sticky_d;
        end
    end

    assign out_valid    = main_vld_q;
    assign result       = main_q.result;
    assign branch_taken = main_q.branch_taken;
    assign wr_en_o      = main_q.wr_en;
    assign wr_reg_o     = main_q.wr_reg;
    assign ofl_sticky   = ofl_sticky_q;

endmodule
